// File: rtl/lcd_bus_writer_if.sv
// Handshake and LCD bus bundle between the upstream sequencer (master) and lcd_bus_writer (slave).
// Signal names follow the board-level port names used by the rest of the LCD datapath.
interface lcd_bus_writer_if;
    logic [8:0] iDATA;
    logic       iVALID;
    logic       oREADY;
    logic       oBUSY;
    logic       oDONE;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    modport master (
        output iDATA, iVALID,
        input  oREADY, oBUSY, oDONE, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );

    modport slave (
        input  iDATA, iVALID,
        output oREADY, oBUSY, oDONE, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );
endinterface

// File: rtl/lcd_bus_writer.sv
// Writes one 9-bit word (RS + byte) to an HD44780-style LCD bus: setup, enable pulse, hold,
// then the controller's execution wait (long for clear/home), with a valid/ready handshake upstream.
module lcd_bus_writer #(
    parameter int SETUP_CYC     = 4,
    parameter int EN_CYC        = 16,
    parameter int HOLD_CYC      = 4,
    parameter int WAIT_CYC      = 2000,
    parameter int LONG_WAIT_CYC = 82000
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    lcd_bus_writer_if.slave  bus
);

    localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B   = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > LONG_WAIT_CYC) ? MAX_C : LONG_WAIT_CYC;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 17) ? $clog2(MAX_CYC + 1) : 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [8:0]         word_q,  word_d;
    logic               en_q,    en_d;
    logic               done_q,  done_d;
    logic               long_cmd;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign long_cmd = !word_q[8] && (word_q[7:0] inside {8'h01, 8'h02, 8'h03});

    // NOTE: every signal gets its default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        en_d    = en_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.iVALID) begin
                    word_d  = bus.iDATA;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(EN_CYC - 1);
                    en_d    = 1'b1;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    en_d    = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = long_cmd ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                en_d    = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= 9'h000;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    // The captured word drives the bus directly, so RS/DATA are stable for the whole transfer.
    assign bus.LCD_RS   = word_q[8];
    assign bus.LCD_DATA = word_q[7:0];
    assign bus.LCD_RW   = 1'b0;
    assign bus.LCD_EN   = en_q;
    assign bus.oREADY   = (state_q == ST_IDLE);
    assign bus.oBUSY    = (state_q != ST_IDLE);
    assign bus.oDONE    = done_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Self-checking bench for lcd_bus_writer: vector table, directed corner sequences and random
// traffic compared against a transfer-level timing model built from the bus monitor's offer log.
module tb_lcd_bus_writer;

    localparam int S = 4;
    localparam int E = 16;
    localparam int H = 4;
    localparam int W = 50;
    localparam int L = 400;
    localparam int BUDGET = S + E + H + L + 40;

    typedef struct {
        int         cyc;
        logic [8:0] w;
    } ev_t;

    typedef struct {
        logic [8:0] word;
        logic       exp_rs;
        logic [7:0] exp_byte;
        bit         exp_long;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic en_prev = 1'b0;

    ev_t offer_q[$];
    ev_t rise_q[$];
    ev_t fall_q[$];
    int  hs_q[$];
    int  done_q[$];

    lcd_bus_writer_if bus_if ();

    lcd_bus_writer #(
        .SETUP_CYC     (S),
        .EN_CYC        (E),
        .HOLD_CYC      (H),
        .WAIT_CYC      (W),
        .LONG_WAIT_CYC (L)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus monitor: samples on the falling edge, mid-cycle; cycle numbers are monitor counts.
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        en_prev <= bus_if.LCD_EN;
        if (rst_n) begin
            if (bus_if.iVALID) offer_q.push_back('{cyc, bus_if.iDATA});
            if (bus_if.iVALID && bus_if.oREADY) hs_q.push_back(cyc);
            if (bus_if.LCD_EN && !en_prev) rise_q.push_back('{cyc, {bus_if.LCD_RS, bus_if.LCD_DATA}});
            if (!bus_if.LCD_EN && en_prev) fall_q.push_back('{cyc, {bus_if.LCD_RS, bus_if.LCD_DATA}});
            if (bus_if.oDONE) done_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wait_len(input logic [8:0] w);
        if (w[8] == 1'b0 && w[7:0] >= 8'd1 && w[7:0] <= 8'd3) return L;
        return W;
    endfunction

    task automatic clear_log();
        offer_q.delete();
        rise_q.delete();
        fall_q.delete();
        hs_q.delete();
        done_q.delete();
    endtask

    // Offer a word and hold it until it is accepted; returns just after the accepting edge.
    task automatic send(input logic [8:0] w);
        int n = 0;
        @(posedge clk); #1;
        bus_if.iVALID = 1'b1;
        bus_if.iDATA  = w;
        while (!bus_if.oREADY && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= BUDGET) check("send_timeout", 1, 0);
        @(posedge clk); #1;
        bus_if.iVALID = 1'b0;
        bus_if.iDATA  = 9'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus_if.oDONE && n < BUDGET);
        check($sformatf("%s_done_timeout", name), n >= BUDGET, 0);
    endtask

    // Transfer-level model: an offer is taken when the writer is idle (done cycle counts as idle);
    // each accepted word fixes its EN rise, EN fall and done cycles from the timing parameters.
    task automatic check_model(input string tag);
        int         idle_from = 0;
        int         exp_rise[$];
        int         exp_done[$];
        logic [8:0] exp_word[$];
        foreach (offer_q[i]) begin
            if (offer_q[i].cyc >= idle_from) begin
                int c;
                c = offer_q[i].cyc;
                exp_rise.push_back(c + S + 1);
                exp_word.push_back(offer_q[i].w);
                exp_done.push_back(c + S + E + H + wait_len(offer_q[i].w) + 1);
                idle_from = c + S + E + H + wait_len(offer_q[i].w) + 1;
            end
        end
        check($sformatf("%s_rise_count", tag), rise_q.size(), exp_rise.size());
        check($sformatf("%s_fall_count", tag), fall_q.size(), exp_rise.size());
        check($sformatf("%s_done_count", tag), done_q.size(), exp_done.size());
        foreach (exp_rise[i]) begin
            if (i < rise_q.size()) begin
                check($sformatf("%s_rise_cyc[%0d]", tag, i), rise_q[i].cyc, exp_rise[i]);
                check($sformatf("%s_rise_word[%0d]", tag, i), rise_q[i].w, exp_word[i]);
            end
            if (i < fall_q.size()) begin
                check($sformatf("%s_fall_cyc[%0d]", tag, i), fall_q[i].cyc, exp_rise[i] + E);
                check($sformatf("%s_fall_word[%0d]", tag, i), fall_q[i].w, exp_word[i]);
            end
            if (i < done_q.size())
                check($sformatf("%s_done_cyc[%0d]", tag, i), done_q[i], exp_done[i]);
        end
    endtask

    vec_t       vecs[8];
    logic [8:0] line[$];

    initial begin
        vecs[0] = '{9'h148, 1'b1, 8'h48, 1'b0};
        vecs[1] = '{9'h001, 1'b0, 8'h01, 1'b1};
        vecs[2] = '{9'h101, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{9'h002, 1'b0, 8'h02, 1'b1};
        vecs[4] = '{9'h003, 1'b0, 8'h03, 1'b1};
        vecs[5] = '{9'h004, 1'b0, 8'h04, 1'b0};
        vecs[6] = '{9'h080, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{9'h1FF, 1'b1, 8'hFF, 1'b0};

        // Reset state, with a word offered while reset is held.
        rst_n         = 1'b0;
        bus_if.iVALID = 1'b1;
        bus_if.iDATA  = 9'h148;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus_if.oREADY, 1);
        check("rst_busy", bus_if.oBUSY, 0);
        check("rst_done", bus_if.oDONE, 0);
        check("rst_en", bus_if.LCD_EN, 0);
        check("rst_rs", bus_if.LCD_RS, 0);
        check("rst_data", bus_if.LCD_DATA, 0);
        check("rst_rw", bus_if.LCD_RW, 0);

        // First handshake on the first edge after release.
        clear_log();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_edge_busy", bus_if.oBUSY, 1);
        bus_if.iVALID = 1'b0;
        wait_done("post_reset");
        @(posedge clk); #1;
        check_model("post_reset");

        // Vector table: one transfer per entry, bus contents and latency against hand values.
        clear_log();
        foreach (vecs[i]) begin
            send(vecs[i].word);
            wait_done("table");
        end
        @(posedge clk); #1;
        check("table_hs_count", hs_q.size(), 8);
        check("table_rise_count", rise_q.size(), 8);
        foreach (vecs[i]) begin
            if (i < hs_q.size() && i < rise_q.size() && i < fall_q.size() && i < done_q.size()) begin
                check($sformatf("table_rs[%0d]", i), rise_q[i].w[8], vecs[i].exp_rs);
                check($sformatf("table_byte[%0d]", i), rise_q[i].w[7:0], vecs[i].exp_byte);
                check($sformatf("table_en_rise[%0d]", i), rise_q[i].cyc - hs_q[i], S + 1);
                check($sformatf("table_en_width[%0d]", i), fall_q[i].cyc - rise_q[i].cyc, E);
                check($sformatf("table_done_lat[%0d]", i), done_q[i] - hs_q[i],
                      S + E + H + (vecs[i].exp_long ? L : W) + 1);
            end
        end

        // Back-to-back: valid held, next word presented during the done cycle.
        clear_log();
        begin
            int n = 0;
            @(posedge clk); #1;
            bus_if.iVALID = 1'b1;
            bus_if.iDATA  = 9'h148;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!bus_if.oDONE && n < BUDGET);
            check("b2b_first_timeout", n >= BUDGET, 0);
            bus_if.iDATA = 9'h14F;
            @(posedge clk); #1;
            bus_if.iVALID = 1'b0;
        end
        wait_done("b2b");
        @(posedge clk); #1;
        check("b2b_hs_count", hs_q.size(), 2);
        if (hs_q.size() == 2 && done_q.size() >= 1 && rise_q.size() == 2) begin
            check("b2b_no_gap", hs_q[1], done_q[0]);
            check("b2b_second_rise", rise_q[1].cyc - done_q[0], S + 1);
            check("b2b_second_word", rise_q[1].w, 9'h14F);
        end
        check_model("b2b");

        // Busy ignore: a second offer during the EN pulse must not disturb the transfer.
        clear_log();
        send(9'h148);
        begin
            int n = 0;
            while (!bus_if.LCD_EN && n < BUDGET) begin
                @(posedge clk); #1;
                n++;
            end
            check("busy_en_timeout", n >= BUDGET, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        bus_if.iVALID = 1'b1;
        bus_if.iDATA  = 9'h155;
        @(posedge clk); #1;
        bus_if.iVALID = 1'b0;
        wait_done("busy");
        @(posedge clk); #1;
        check("busy_one_pulse", rise_q.size(), 1);
        check("busy_one_done", done_q.size(), 1);
        if (fall_q.size() >= 1) check("busy_data_kept", fall_q[0].w, 9'h148);
        check_model("busy");

        // Reset asserted in the 8th EN-high cycle.
        clear_log();
        send(9'h148);
        begin
            int n = 0;
            int k = 0;
            while (k < 8 && n < BUDGET) begin
                @(posedge clk); #1;
                n++;
                if (bus_if.LCD_EN) k++;
            end
            check("rstmid_en_timeout", n >= BUDGET, 0);
        end
        rst_n = 1'b0;
        #1;
        check("rstmid_en", bus_if.LCD_EN, 0);
        check("rstmid_data", bus_if.LCD_DATA, 0);
        check("rstmid_ready", bus_if.oREADY, 1);
        check("rstmid_busy", bus_if.oBUSY, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (S + E + H + W + 10) @(posedge clk);
        #1;
        check("rstmid_no_done", done_q.size(), 0);
        check("rstmid_idle", bus_if.oREADY, 1);
        clear_log();
        send(9'h14F);
        wait_done("rstmid_after");
        @(posedge clk); #1;
        check_model("rstmid_after");

        // Random traffic: offers come and go regardless of ready, with data changing freely.
        clear_log();
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            bus_if.iVALID = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) bus_if.iDATA = {1'b0, 8'($urandom_range(1, 3))};
            else bus_if.iDATA = 9'($urandom);
        end
        @(posedge clk); #1;
        bus_if.iVALID = 1'b0;
        repeat (BUDGET) @(posedge clk);
        #1;
        check_model("random");

        // Full two-line sequence: clear, line-1 address, 16 chars, line-2 address, 16 chars.
        clear_log();
        line.push_back(9'h001);
        line.push_back(9'h080);
        for (int i = 0; i < 16; i++) line.push_back({1'b1, 8'h41 + 8'(i)});
        line.push_back(9'h0C0);
        for (int i = 0; i < 16; i++) line.push_back({1'b1, 8'h61 + 8'(i)});
        foreach (line[i]) send(line[i]);
        wait_done("line");
        @(posedge clk); #1;
        check("line_rise_count", rise_q.size(), line.size());
        foreach (line[i]) begin
            if (i < rise_q.size() && i < fall_q.size()) begin
                check($sformatf("line_word[%0d]", i), rise_q[i].w, line[i]);
                check($sformatf("line_width[%0d]", i), fall_q[i].cyc - rise_q[i].cyc, E);
            end
        end
        check_model("line");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
